// File: rtl/reg_file.sv
// 32 x 64-bit RISC-V integer register file: two combinational read ports, one write port, x0 hardwired to zero.
// Optional write-through forwarding from Din to the read ports is enabled by defining REGFILE_BYPASS_EN.
module reg_file (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    input  logic [4:0]  Rw,
    input  logic        WE,
    input  logic [63:0] Din,
    output logic [63:0] Da,
    output logic [63:0] Db
);

    logic [63:0] regs_r [1:31];
    logic [31:0] wr_sel_s;
    logic [63:0] view_s [0:31];
    logic        fwd_a_s;
    logic        fwd_b_s;

    // One-hot write decode gated by WE; bit 0 is never set so x0 writes vanish.
    always_comb begin
        wr_sel_s = 32'd0;
        if (WE && (Rw != 5'd0)) begin
            wr_sel_s[Rw] = 1'b1;
        end else begin
            wr_sel_s = 32'd0;
        end
    end

    // Register storage x1..x31; reset clears asynchronously and wins over any write edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 1; i < 32; i++) begin
                regs_r[i] <= 64'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= Din;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Full 32-entry read view with a constant zero in slot 0.
    always_comb begin
        view_s[0] = 64'd0;
        for (int i = 1; i < 32; i++) begin
            view_s[i] = regs_r[i];
        end
    end

    // Forwarding qualifiers: only a live, non-x0 write that matches the read address.
    always_comb begin
        fwd_a_s = 1'b0;
        fwd_b_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (RST_N && WE && (Rw != 5'd0)) begin
            fwd_a_s = (Rw == Ra);
            fwd_b_s = (Rw == Rb);
        end else begin
            fwd_a_s = 1'b0;
            fwd_b_s = 1'b0;
        end
`endif
    end

    // Read port A.
    always_comb begin
        Da = 64'd0;
        if (fwd_a_s) begin
            Da = Din;
        end else begin
            Da = view_s[Ra];
        end
    end

    // Read port B.
    always_comb begin
        Db = 64'd0;
        if (fwd_b_s) begin
            Db = Din;
        end else begin
            Db = view_s[Rb];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test-plan cases plus randomized traffic against an array model.
module tb_reg_file;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [4:0]  Rw;
    logic        WE;
    logic [63:0] Din;
    logic [63:0] Da;
    logic [63:0] Db;

    int n_cmp;
    int n_err;
    logic [63:0] model [0:31];

    reg_file dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .Ra   (Ra),
        .Rb   (Rb),
        .Rw   (Rw),
        .WE   (WE),
        .Din  (Din),
        .Da   (Da),
        .Db   (Db)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    // Architectural model: array of 32 registers, x0 kept at zero.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) model[i] <= 64'd0;
        end else if (WE && Rw != 5'd0) begin
            model[Rw] <= Din;
        end
    end

    function automatic logic [63:0] expect_read(input logic [4:0] addr);
        logic [63:0] v;
        v = (addr == 5'd0) ? 64'd0 : model[addr];
`ifdef REGFILE_BYPASS_EN
        if (RST_N === 1'b1 && WE && Rw != 5'd0 && Rw == addr) v = Din;
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t Ra=%0d Rb=%0d Rw=%0d WE=%b)",
                     name, act, exp, $time, Ra, Rb, Rw, WE);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge CLK) begin
        check("cyc_Da", Da, expect_read(Ra));
        check("cyc_Db", Db, expect_read(Rb));
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sweep_all(input string name);
        for (int a = 0; a < 32; a++) begin
            Ra = a[4:0];
            Rb = 5'(31 - a);
            #1;
            check(name, Da, expect_read(Ra));
            check(name, Db, expect_read(Rb));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        WE = 1'b0; Rw = 5'd0; Din = 64'd0; Ra = 5'd5; Rb = 5'd31;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #2;
        check("reset_Da", Da, 64'd0);
        check("reset_Db", Db, 64'd0);
        #20 RST_N = 1'b1;
        #2;
        check("post_reset_Da", Da, 64'd0);
        check("post_reset_Db", Db, 64'd0);

        // Basic write/read.
        next_cycle();
        WE = 1'b1; Rw = 5'd1; Din = 64'd234; Ra = 5'd0; Rb = 5'd1;
        next_cycle();
        check("basic_Db_x1", Db, 64'd234);
        check("basic_Da_x0", Da, 64'd0);
        Rw = 5'd18; Din = 64'd672; Ra = 5'd18;
        next_cycle();
        check("basic_Da_x18", Da, 64'd672);
        check("basic_Db_keep", Db, 64'd234);

        // x0 protection.
        Rw = 5'd0; Din = 64'hFFFF_FFFF_FFFF_FFFF; Ra = 5'd0; Rb = 5'd18;
        next_cycle();
        check("x0_Da", Da, 64'd0);
        check("x0_Db_x18", Db, 64'd672);
        WE = 1'b0;
        sweep_all("x0_sweep");

        // Write disable.
        next_cycle();
        WE = 1'b0; Rw = 5'd3; Din = 64'd99; Ra = 5'd3;
        repeat (3) next_cycle();
        check("we0_x3", Da, 64'd0);

        // Read-during-write on x7.
        WE = 1'b1; Rw = 5'd7; Din = 64'd10;
        next_cycle();
        Din = 64'd20; Ra = 5'd7; Rb = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_Da", Da, 64'd20);
        check("rdw_before_Db", Db, 64'd20);
`else
        check("rdw_before_Da", Da, 64'd10);
        check("rdw_before_Db", Db, 64'd10);
`endif
        next_cycle();
        WE = 1'b0;
        #1;
        check("rdw_after_Da", Da, 64'd20);
        check("rdw_after_Db", Db, 64'd20);

        // Fill x1..x31 with index*3, then reset mid-operation.
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            WE = 1'b1; Rw = i[4:0]; Din = 64'(i * 3);
        end
        next_cycle();
        WE = 1'b0;
        Ra = 5'd31; Rb = 5'd10;
        #1;
        check("fill_x31", Da, 64'd93);
        check("fill_x10", Db, 64'd30);
        sweep_all("fill_sweep");
        #2 RST_N = 1'b0;
        #1;
        sweep_all("midreset_sweep");
        WE = 1'b1; Rw = 5'd5; Din = 64'd77; Ra = 5'd5; Rb = 5'd5;
        next_cycle();
        check("reset_write_ignored", Da, 64'd0);
        WE = 1'b0;
        RST_N = 1'b1;
        #1;
        check("after_release_x5", Db, 64'd0);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            RST_N = 1'b1;
            WE  = ($urandom_range(0, 3) != 0);
            Rw  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            Din = {$urandom, $urandom};
            Ra  = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            Rb  = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) begin
                #3 RST_N = 1'b0;
            end
        end
        next_cycle();
        RST_N = 1'b1;
        WE = 1'b0;
        sweep_all("final_sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
